// File: rtl/spi_mem_loader.sv
// SPI mode-0 slave that turns host frames into auto-incrementing single-cycle
// byte writes into the SNN parameter memory; SPI pins are oversampled on clk.
module spi_mem_loader #(
    parameter int MEM_DEPTH   = 101,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic [7:0]        mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              frame_done,
    output logic              overflow,
    output logic [7:0]        byte_count
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DISCARD} state_e;

    localparam logic [7:0]      TX_PREAMBLE = 8'hA5;
    localparam logic [ADDR_W:0] DEPTH_LIM   = (ADDR_W + 1)'(MEM_DEPTH);

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_dly_q, cs_dly_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_e              state_q, state_d;
    logic [7:0]          rx_q, rx_d;
    logic [7:0]          tx_q, tx_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic                byte_done_q, byte_done_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]          mem_data_q, mem_data_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic                frame_done_q, frame_done_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          byte_count_q, byte_count_d;

    // NOTE: the cs_n chain resets to 1 (deselected) so leaving reset never fakes a frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_dly_q  <= sclk_s;
            cs_dly_q    <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign cs_rise   = cs_s & ~cs_dly_q;
    assign cs_fall   = ~cs_s & cs_dly_q;

    // NOTE: every _d is given its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d      = state_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        bit_cnt_d    = bit_cnt_q;
        byte_done_d  = 1'b0;
        ptr_d        = ptr_q;
        mem_data_d   = mem_data_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        byte_count_d = byte_count_q;

        // Deselected: keep the preamble staged so its MSB is on miso as cs_n falls.
        if (cs_s) begin
            bit_cnt_d = '0;
            tx_d      = TX_PREAMBLE;
        end else if (sclk_rise) begin
            rx_d      = {rx_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_done_d = 1'b1;
                tx_d        = {rx_q[6:0], mosi_s};
            end
        end else if (sclk_fall && bit_cnt_q != 3'd0) begin
            // The falling edge right after a byte boundary keeps the freshly loaded echo MSB.
            tx_d = {tx_q[6:0], 1'b0};
        end

        if (cs_rise && state_q != IDLE) begin
            state_d      = IDLE;
            frame_done_d = (state_q == DATA) || (state_q == DISCARD);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d      = CMD;
                        byte_count_d = '0;
                    end
                end
                CMD: begin
                    if (byte_done_q) begin
                        if (rx_q[7]) begin
                            state_d = DATA;
                            ptr_d   = rx_q[ADDR_W-1:0];
                        end else begin
                            state_d = DISCARD;
                        end
                    end
                end
                DATA: begin
                    if (byte_done_q) begin
                        if ({1'b0, ptr_q} < DEPTH_LIM) begin
                            mem_we_d   = 1'b1;
                            mem_data_d = rx_q;
                            mem_addr_d = ptr_q;
                            ptr_d      = ptr_q + ADDR_W'(1);
                            if (byte_count_q != 8'hFF) begin
                                byte_count_d = byte_count_q + 8'd1;
                            end
                        end else begin
                            overflow_d = 1'b1;
                            state_d    = DISCARD;
                        end
                    end
                end
                DISCARD: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rx_q         <= '0;
            tx_q         <= '0;
            bit_cnt_q    <= '0;
            byte_done_q  <= 1'b0;
            ptr_q        <= '0;
            mem_data_q   <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_done_q  <= byte_done_d;
            ptr_q        <= ptr_d;
            mem_data_q   <= mem_data_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign miso       = tx_q[7] & ~cs_s;
    assign mem_data   = mem_data_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_spi_mem_loader.sv
// Randomised and directed SPI frames for spi_mem_loader, compared against a
// byte-level model of the frame rules (writes, count, overflow, echo).
module tb_spi_mem_loader;

    localparam int  MEM_DEPTH = 101;
    localparam int  ADDR_W    = 7;
    localparam time HALF_SCLK = 60ns;

    logic              clk = 1'b0;
    logic              reset, sclk, cs_n, mosi;
    logic              miso, mem_we, frame_done, overflow;
    logic [7:0]        mem_data, byte_count;
    logic [ADDR_W-1:0] mem_addr;

    always #5 clk = ~clk;

    spi_mem_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .mem_data(mem_data), .mem_addr(mem_addr), .mem_we(mem_we),
        .frame_done(frame_done), .overflow(overflow), .byte_count(byte_count)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Observed write strobes and frame_done pulses.
    logic [ADDR_W+7:0] wr_q[$];
    int                fd_cnt  = 0;
    logic              we_prev = 1'b0;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_q.push_back({mem_addr, mem_data});
            check("we_single_cycle", 32'(we_prev), 32'd0);
        end
        if (frame_done) fd_cnt++;
        we_prev = mem_we;
    end

    // Current frame and reference-model state.
    logic [7:0]        fr_b[16];
    int                fr_n, fr_extra;
    logic [7:0]        fr_tail;
    logic [7:0]        miso_bytes[16];
    logic [ADDR_W+7:0] exp_q[$];
    logic              m_ovf;
    logic [ADDR_W-1:0] m_last_addr;
    logic [7:0]        m_last_data;

    task automatic send_bits(input logic [7:0] b, input int n, input int idx);
        logic [7:0] sh;
        sh = '0;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            #HALF_SCLK;
            sh   = {sh[6:0], miso};
            sclk = 1'b1;
            #HALF_SCLK;
            sclk = 1'b0;
        end
        if (n == 8) miso_bytes[idx] = sh;
    endtask

    task automatic set_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input int extra, input logic [7:0] tail);
        fr_n     = n;
        fr_b[0]  = b0;
        fr_b[1]  = b1;
        fr_b[2]  = b2;
        fr_b[3]  = b3;
        fr_extra = extra;
        fr_tail  = tail;
    endtask

    // Frame rules at byte level: command byte, then writes until the range end.
    task automatic model_frame(output logic exp_fd, output logic [7:0] exp_cnt);
        int ptr;
        exp_q.delete();
        exp_fd  = (fr_n >= 1);
        exp_cnt = 8'd0;
        if (fr_n >= 1 && fr_b[0][7]) begin
            ptr = int'(fr_b[0][6:0]);
            for (int k = 1; k < fr_n; k++) begin
                if (ptr >= MEM_DEPTH) begin
                    m_ovf = 1'b1;
                    break;
                end
                exp_q.push_back({ADDR_W'(ptr), fr_b[k]});
                m_last_addr = ADDR_W'(ptr);
                m_last_data = fr_b[k];
                ptr++;
                if (exp_cnt != 8'hFF) exp_cnt++;
            end
        end
    endtask

    task automatic run_frame();
        logic       exp_fd;
        logic [7:0] exp_cnt;
        logic [7:0] exp_miso;
        model_frame(exp_fd, exp_cnt);
        wr_q.delete();
        fd_cnt = 0;
        cs_n = 1'b0;
        #100ns;
        for (int k = 0; k < fr_n; k++) send_bits(fr_b[k], 8, k);
        if (fr_extra > 0) send_bits(fr_tail, fr_extra, fr_n);
        #200ns;
        cs_n = 1'b1;
        #200ns;
        check("frame_done_count", 32'(fd_cnt), 32'(exp_fd));
        check("write_count", 32'(wr_q.size()), 32'(exp_q.size()));
        while (wr_q.size() > 0 && exp_q.size() > 0)
            check("write_addr_data", 32'(wr_q.pop_front()), 32'(exp_q.pop_front()));
        check("byte_count", 32'(byte_count), 32'(exp_cnt));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("mem_addr_hold", 32'(mem_addr), 32'(m_last_addr));
        check("mem_data_hold", 32'(mem_data), 32'(m_last_data));
        for (int k = 0; k < fr_n; k++) begin
            exp_miso = (k == 0) ? 8'hA5 : fr_b[k-1];
            check("miso_byte", 32'(miso_bytes[k]), 32'(exp_miso));
        end
        check("miso_deselected", 32'(miso), 32'd0);
    endtask

    task automatic check_all_zero();
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        m_ovf       = 1'b0;
        m_last_addr = '0;
        m_last_data = '0;
        #22ns;
        check_all_zero();
        #30ns;
        reset = 1'b0;
        #100ns;
        check_all_zero();

        set_frame(4, 8'h85, 8'h11, 8'h22, 8'h33, 0, 8'h00);   // three writes at 5..7
        run_frame();
        set_frame(4, 8'hE3, 8'hAA, 8'hBB, 8'hCC, 0, 8'h00);   // range end, overflow
        run_frame();
        set_frame(2, 8'h05, 8'h44, 8'h00, 8'h00, 0, 8'h00);   // invalid command
        run_frame();
        set_frame(2, 8'h80, 8'h5A, 8'h00, 8'h00, 4, 8'hC0);   // trailing partial byte
        run_frame();
        set_frame(3, 8'h80, 8'h12, 8'h34, 8'h00, 0, 8'h00);   // miso echo
        run_frame();

        for (int f = 0; f < 25; f++) begin
            fr_n = $urandom_range(0, 7);
            for (int k = 0; k < fr_n; k++) fr_b[k] = 8'($urandom);
            if (fr_n > 0) begin
                fr_b[0][7] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 1) fr_b[0][6:0] = 7'($urandom_range(94, 127));
            end
            fr_extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
            fr_tail  = 8'($urandom);
            run_frame();
        end

        // Asynchronous reset in the middle of a data byte.
        wr_q.delete();
        fd_cnt = 0;
        cs_n = 1'b0;
        #100ns;
        send_bits(8'h80, 8, 0);
        send_bits(8'h11, 8, 1);
        send_bits(8'hF0, 3, 2);
        check("pre_reset_writes", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) check("pre_reset_write", 32'(wr_q.pop_front()), 32'h0011);
        #7ns;
        reset = 1'b1;
        #1ns;
        check_all_zero();
        cs_n = 1'b1;
        #52ns;
        reset = 1'b0;
        m_ovf       = 1'b0;
        m_last_addr = '0;
        m_last_data = '0;
        wr_q.delete();
        fd_cnt = 0;
        #200ns;
        check("post_reset_no_frame_done", 32'(fd_cnt), 32'd0);
        check("post_reset_no_write", 32'(wr_q.size()), 32'd0);
        set_frame(2, 8'h81, 8'h77, 8'h00, 8'h00, 0, 8'h00);
        run_frame();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
